bsg_bladerunner_mem_cfg_responder: RTL and testbench
====================================================

Name: bsg_bladerunner_mem_cfg_responder

Overview:
- Host-facing readback responder for the Bladerunner memory configuration. It answers indexed read requests with the build-time memory-configuration enum, its decoded LEVEL1/2/3 fields and the vcache geometry.
- It is the reader/decoder end of the memory-configuration enum encoding.
- It sits behind the host MMIO/config-ROM path and lets host software discover which memory system was built.
- It uses a single-entry registered response with a valid/ready request side and a valid/yumi response side.

Parameters:
- mem_cfg_p, e_vcache_blocking_axi4_f1_model, memory-configuration enum value (bsg_bladerunner_mem_cfg_e).
- num_vcache_p, 32, number of vcaches.
- vcache_sets_p, 64, sets per vcache.
- vcache_ways_p, 8, ways per vcache.
- vcache_block_size_in_words_p, 8, words per cache block.
- data_width_p, 32, response width; must be at least 32.
- addr_width_p, 4, request index width.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  synchronous active-low reset.
- v_i  in  1  request valid.
- addr_i  in  addr_width_p  request index.
- ready_and_o  out  1  request accepted when v_i & ready_and_o.
- v_o  out  1  response valid.
- data_o  out  data_width_p  response data.
- err_o  out  1  response is to an unmapped index; qualified by v_o.
- yumi_i  in  1  response consumed; only legal when v_o=1.

Behaviour:
- Reset (reset_n_i=0 at posedge): v_o=0, data_o=0, err_o=0, req_count=0. ready_and_o is combinational and equals 1 while v_o=0, so it reads 1 during and after reset.
- ready_and_o = ~v_o | yumi_i. This gives full throughput of one response per cycle under continuous yumi.
- Accept (v_i & ready_and_o): at the next posedge v_o=1 and data_o/err_o hold the lookup of addr_i. Latency is exactly 1 cycle.
- If yumi_i and no accept: v_o clears at the next posedge. data_o holds its last value.
- If yumi_i and accept in the same cycle: v_o stays 1 and data_o is replaced by the new lookup, with no bubble.
- While v_o=1 & ~yumi_i: data_o and err_o are stable, and ready_and_o=0.
- Index map (all values zero-extended to data_width_p):
  - 0: mem_cfg_p.
  - 1: LEVEL1 code: 0 infinite_mem, 1 vcache_blocking, 2 vcache_non_blocking.
  - 2: LEVEL2 code: 0 none, 1 axi4, 2 test.
  - 3: LEVEL3 code: 0 none, 1 f1_dram, 2 f1_model, 3 dramsim3_hbm2_4gb_x128.
  - 4: num_vcache_p.
  - 5: vcache_sets_p.
  - 6: vcache_ways_p.
  - 7: vcache_block_size_in_words_p.
  - 8: req_count, captured before the increment for this request.
  - 9..max: data 32'hDEAD_BEEF, err_o=1.
- An unknown mem_cfg_p (not a listed enum member) returns 32'hF for indices 1-3, with err_o=0. Index 0 still returns the raw value.
- Decode of indices 1-3 is computed once from the parameter. The lookup is combinational from addr_i and registered into data_o.
- req_count: data_width_p bits, incremented on every accept including unmapped indices, and wraps 0xFFFF_FFFF -> 0.
- Reset mid-transaction: a pending response is dropped (v_o=0). A request presented in the reset cycle is not accepted and does not count.
- Assertions (nonsynth): yumi_i implies v_o; data_width_p >= 32.

Decomposition:
- Shared package bsg_bladerunner_mem_cfg_pkg gains:
  - the level code typedefs bsg_mem_cfg_level1_e, bsg_mem_cfg_level2_e and bsg_mem_cfg_level3_e;
  - the index localparams e_mem_cfg_idx_cfg ... e_mem_cfg_idx_count;
  - the constant mem_cfg_bad_idx_data = 32'hDEAD_BEEF.
- One sub-module, bsg_bladerunner_mem_cfg_decode. It is purely combinational: mem_cfg enum in, three level codes plus an unknown flag out. It is reused by the host driver model.

Test Plan:
1. Default params; after reset, request idx 0 with yumi held 1 -> next cycle v_o=1, data_o=mem_cfg_p (value 2), err_o=0; ready_and_o=1 throughout.
2. mem_cfg_p=e_vcache_non_blocking_test_dramsim3_hbm2_4gb_x128; read idx 1,2,3 back-to-back with yumi=1 -> data 2,2,3 on consecutive cycles, no bubbles.
3. Read idx 4..7 with default geometry -> 32,64,8,8. Then idx 12 -> data 0xDEADBEEF, err_o=1.
4. Backpressure: accept idx 5, hold yumi_i=0 for 4 cycles while v_i=1 on idx 6 -> ready_and_o=0 and data_o=64 stable. On yumi_i=1, idx 6 is accepted the same cycle and data_o=8 next cycle.
5. Counter: issue 10 requests, then read idx 8 -> data 10. Force req_count to 0xFFFFFFFF, read idx 8 twice -> 0xFFFFFFFF then 0.
6. Assert reset_n_i=0 while v_o=1 -> v_o=0, req_count=0 next cycle. Then e_infinite_mem build, idx 1..3 -> 0,0,0.

Source files
------------

// File: rtl/bsg_bladerunner_mem_cfg_pkg.sv
// Memory-configuration enum, its decoded level codes and the readback index map
// shared by the config responder and the host driver model.
package bsg_bladerunner_mem_cfg_pkg;

  localparam int unsigned mem_cfg_width_lp = 8;
  localparam int unsigned level_width_lp   = 2;

  typedef enum logic [mem_cfg_width_lp-1:0] {
    e_infinite_mem                                    = 8'd0,
    e_vcache_blocking_axi4_f1_dram                    = 8'd1,
    e_vcache_blocking_axi4_f1_model                   = 8'd2,
    e_vcache_non_blocking_axi4_f1_dram                = 8'd3,
    e_vcache_non_blocking_axi4_f1_model               = 8'd4,
    e_vcache_blocking_test_dramsim3_hbm2_4gb_x128     = 8'd5,
    e_vcache_non_blocking_test_dramsim3_hbm2_4gb_x128 = 8'd6
  } bsg_bladerunner_mem_cfg_e;

  typedef enum logic [level_width_lp-1:0] {
    e_level1_infinite_mem        = 2'd0,
    e_level1_vcache_blocking     = 2'd1,
    e_level1_vcache_non_blocking = 2'd2
  } bsg_mem_cfg_level1_e;

  typedef enum logic [level_width_lp-1:0] {
    e_level2_none = 2'd0,
    e_level2_axi4 = 2'd1,
    e_level2_test = 2'd2
  } bsg_mem_cfg_level2_e;

  typedef enum logic [level_width_lp-1:0] {
    e_level3_none                   = 2'd0,
    e_level3_f1_dram                = 2'd1,
    e_level3_f1_model               = 2'd2,
    e_level3_dramsim3_hbm2_4gb_x128 = 2'd3
  } bsg_mem_cfg_level3_e;

  // Readback index map; anything above e_mem_cfg_idx_count is unmapped.
  localparam logic [31:0] e_mem_cfg_idx_cfg        = 32'd0;
  localparam logic [31:0] e_mem_cfg_idx_level1     = 32'd1;
  localparam logic [31:0] e_mem_cfg_idx_level2     = 32'd2;
  localparam logic [31:0] e_mem_cfg_idx_level3     = 32'd3;
  localparam logic [31:0] e_mem_cfg_idx_num_vcache = 32'd4;
  localparam logic [31:0] e_mem_cfg_idx_sets       = 32'd5;
  localparam logic [31:0] e_mem_cfg_idx_ways       = 32'd6;
  localparam logic [31:0] e_mem_cfg_idx_block_size = 32'd7;
  localparam logic [31:0] e_mem_cfg_idx_count      = 32'd8;

  localparam logic [31:0] mem_cfg_bad_idx_data     = 32'hDEAD_BEEF;
  localparam logic [31:0] mem_cfg_unknown_data     = 32'h0000_000F;

endpackage

// File: rtl/bsg_bladerunner_mem_cfg_decode.sv
// Splits a memory-configuration enum into its LEVEL1/2/3 codes; flags values
// that are not members of the enum.
module bsg_bladerunner_mem_cfg_decode
  import bsg_bladerunner_mem_cfg_pkg::*;
(
  input  bsg_bladerunner_mem_cfg_e i_mem_cfg,
  output bsg_mem_cfg_level1_e      o_level1_c,
  output bsg_mem_cfg_level2_e      o_level2_c,
  output bsg_mem_cfg_level3_e      o_level3_c,
  output logic                     o_unknown_c
);

  always_comb begin
    o_level1_c  = e_level1_infinite_mem;
    o_level2_c  = e_level2_none;
    o_level3_c  = e_level3_none;
    o_unknown_c = 1'b0;
    case (i_mem_cfg)
      e_infinite_mem: begin
        o_level1_c = e_level1_infinite_mem;
      end
      e_vcache_blocking_axi4_f1_dram: begin
        o_level1_c = e_level1_vcache_blocking;
        o_level2_c = e_level2_axi4;
        o_level3_c = e_level3_f1_dram;
      end
      e_vcache_blocking_axi4_f1_model: begin
        o_level1_c = e_level1_vcache_blocking;
        o_level2_c = e_level2_axi4;
        o_level3_c = e_level3_f1_model;
      end
      e_vcache_non_blocking_axi4_f1_dram: begin
        o_level1_c = e_level1_vcache_non_blocking;
        o_level2_c = e_level2_axi4;
        o_level3_c = e_level3_f1_dram;
      end
      e_vcache_non_blocking_axi4_f1_model: begin
        o_level1_c = e_level1_vcache_non_blocking;
        o_level2_c = e_level2_axi4;
        o_level3_c = e_level3_f1_model;
      end
      e_vcache_blocking_test_dramsim3_hbm2_4gb_x128: begin
        o_level1_c = e_level1_vcache_blocking;
        o_level2_c = e_level2_test;
        o_level3_c = e_level3_dramsim3_hbm2_4gb_x128;
      end
      e_vcache_non_blocking_test_dramsim3_hbm2_4gb_x128: begin
        o_level1_c = e_level1_vcache_non_blocking;
        o_level2_c = e_level2_test;
        o_level3_c = e_level3_dramsim3_hbm2_4gb_x128;
      end
      default: begin
        o_unknown_c = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/bsg_bladerunner_mem_cfg_responder.sv
// Host readback responder for the build-time memory configuration: indexed
// valid/ready requests, single-entry registered valid/yumi response.
module bsg_bladerunner_mem_cfg_responder
  import bsg_bladerunner_mem_cfg_pkg::*;
#(
  parameter bsg_bladerunner_mem_cfg_e mem_cfg_p    = e_vcache_blocking_axi4_f1_model,
  parameter int unsigned num_vcache_p                 = 32,
  parameter int unsigned vcache_sets_p                = 64,
  parameter int unsigned vcache_ways_p                = 8,
  parameter int unsigned vcache_block_size_in_words_p = 8,
  parameter int unsigned data_width_p                 = 32,
  parameter int unsigned addr_width_p                 = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    v_i,
  input  logic [addr_width_p-1:0] addr_i,
  output logic                    ready_and_o,
  output logic                    v_o,
  output logic [data_width_p-1:0] data_o,
  output logic                    err_o,
  input  logic                    yumi_i
);

  if (data_width_p < 32) begin : g_width_check
    $error("bsg_bladerunner_mem_cfg_responder: data_width_p must be at least 32");
  end

  logic                    r_v;
  logic [data_width_p-1:0] r_data;
  logic                    r_err;
  logic [data_width_p-1:0] r_req_count;

  logic                    w_v_next;
  logic [data_width_p-1:0] w_data_next;
  logic                    w_err_next;
  logic [data_width_p-1:0] w_count_next;

  logic                    w_accept;
  logic [31:0]             w_idx;
  logic [data_width_p-1:0] w_lookup_data;
  logic                    w_lookup_err;

  bsg_mem_cfg_level1_e     w_level1;
  bsg_mem_cfg_level2_e     w_level2;
  bsg_mem_cfg_level3_e     w_level3;
  logic                    w_unknown;

  // Level decode of the build parameter; constant after elaboration.
  bsg_bladerunner_mem_cfg_decode u_decode (
    .i_mem_cfg   (mem_cfg_p),
    .o_level1_c  (w_level1),
    .o_level2_c  (w_level2),
    .o_level3_c  (w_level3),
    .o_unknown_c (w_unknown)
  );

  assign ready_and_o = ~r_v | yumi_i;
  assign w_accept    = v_i & ready_and_o;
  assign w_idx       = 32'(addr_i);

  // Index lookup; the count slot reports the value before this request's increment.
  always_comb begin
    w_lookup_data = '0;
    w_lookup_err  = 1'b0;
    case (w_idx)
      e_mem_cfg_idx_cfg:        w_lookup_data = data_width_p'(mem_cfg_p);
      e_mem_cfg_idx_level1:     w_lookup_data = w_unknown ? data_width_p'(mem_cfg_unknown_data)
                                                          : data_width_p'(w_level1);
      e_mem_cfg_idx_level2:     w_lookup_data = w_unknown ? data_width_p'(mem_cfg_unknown_data)
                                                          : data_width_p'(w_level2);
      e_mem_cfg_idx_level3:     w_lookup_data = w_unknown ? data_width_p'(mem_cfg_unknown_data)
                                                          : data_width_p'(w_level3);
      e_mem_cfg_idx_num_vcache: w_lookup_data = data_width_p'(num_vcache_p);
      e_mem_cfg_idx_sets:       w_lookup_data = data_width_p'(vcache_sets_p);
      e_mem_cfg_idx_ways:       w_lookup_data = data_width_p'(vcache_ways_p);
      e_mem_cfg_idx_block_size: w_lookup_data = data_width_p'(vcache_block_size_in_words_p);
      e_mem_cfg_idx_count:      w_lookup_data = r_req_count;
      default: begin
        w_lookup_data = data_width_p'(mem_cfg_bad_idx_data);
        w_lookup_err  = 1'b1;
      end
    endcase
  end

  // Response slot: a new accept overwrites in place, so yumi+accept has no bubble.
  always_comb begin
    w_v_next     = r_v;
    w_data_next  = r_data;
    w_err_next   = r_err;
    w_count_next = r_req_count;
    if (w_accept) begin
      w_v_next     = 1'b1;
      w_data_next  = w_lookup_data;
      w_err_next   = w_lookup_err;
      w_count_next = r_req_count + data_width_p'(1);
    end else if (yumi_i) begin
      w_v_next     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_v         <= 1'b0;
      r_data      <= '0;
      r_err       <= 1'b0;
      r_req_count <= '0;
    end else begin
      r_v         <= w_v_next;
      r_data      <= w_data_next;
      r_err       <= w_err_next;
      r_req_count <= w_count_next;
    end
  end

  assign v_o    = r_v;
  assign data_o = r_data;
  assign err_o  = r_err;

  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!yumi_i || r_v) else $error("yumi_i asserted while v_o is low");
    end
  end

endmodule

// File: tb/tb_bsg_bladerunner_mem_cfg_responder.sv
// Bench for the memory-config responder: four builds share one stimulus stream
// and are checked against a table-driven readback model.
module tb_bsg_bladerunner_mem_cfg_responder;
  import bsg_bladerunner_mem_cfg_pkg::*;

  localparam int NI = 4;
  // Builds: default f1_model, non_blocking_test_dramsim3, infinite_mem, unknown(99).
  localparam logic [31:0] CFG_RAW [NI]    = '{32'd2, 32'd6, 32'd0, 32'd99};
  localparam logic [31:0] CFG_LV  [NI][3] = '{'{32'd1, 32'd1, 32'd2},
                                              '{32'd2, 32'd2, 32'd3},
                                              '{32'd0, 32'd0, 32'd0},
                                              '{32'hF, 32'hF, 32'hF}};

  logic        clk;
  logic        reset_n;
  logic        v_i;
  logic [3:0]  addr_i;
  logic        yumi_i;
  logic        ready_o [NI];
  logic        v_o     [NI];
  logic [31:0] data_o  [NI];
  logic        err_o   [NI];

  int n_tests = 0;
  int n_fail  = 0;

  logic        m_v;
  logic [31:0] m_count;
  logic [31:0] m_data [NI];
  logic        m_err  [NI];

  bsg_bladerunner_mem_cfg_responder #(.mem_cfg_p(e_vcache_blocking_axi4_f1_model)) u_dut0 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .addr_i(addr_i), .ready_and_o(ready_o[0]),
    .v_o(v_o[0]), .data_o(data_o[0]), .err_o(err_o[0]), .yumi_i(yumi_i));
  bsg_bladerunner_mem_cfg_responder #(.mem_cfg_p(e_vcache_non_blocking_test_dramsim3_hbm2_4gb_x128)) u_dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .addr_i(addr_i), .ready_and_o(ready_o[1]),
    .v_o(v_o[1]), .data_o(data_o[1]), .err_o(err_o[1]), .yumi_i(yumi_i));
  bsg_bladerunner_mem_cfg_responder #(.mem_cfg_p(e_infinite_mem)) u_dut2 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .addr_i(addr_i), .ready_and_o(ready_o[2]),
    .v_o(v_o[2]), .data_o(data_o[2]), .err_o(err_o[2]), .yumi_i(yumi_i));
  bsg_bladerunner_mem_cfg_responder #(.mem_cfg_p(bsg_bladerunner_mem_cfg_e'(8'd99))) u_dut3 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .addr_i(addr_i), .ready_and_o(ready_o[3]),
    .v_o(v_o[3]), .data_o(data_o[3]), .err_o(err_o[3]), .yumi_i(yumi_i));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected {err, data} for index idx on build k with request count cnt.
  function automatic logic [32:0] ref_lookup(input int k, input int idx, input logic [31:0] cnt);
    if (idx == 0) return {1'b0, CFG_RAW[k]};
    if (idx >= 1 && idx <= 3) return {1'b0, CFG_LV[k][idx-1]};
    if (idx == 4) return {1'b0, 32'd32};
    if (idx == 5) return {1'b0, 32'd64};
    if (idx == 6) return {1'b0, 32'd8};
    if (idx == 7) return {1'b0, 32'd8};
    if (idx == 8) return {1'b0, cnt};
    return {1'b1, 32'hDEAD_BEEF};
  endfunction

  task automatic drive(input logic v, input int a, input logic y);
    v_i    = v;
    addr_i = 4'(a);
    yumi_i = y;
    #1;
  endtask

  // Advance one clock and update the model from the inputs presented this cycle.
  task automatic tick();
    logic rst, acc, y;
    int   a;
    rst = !reset_n;
    acc = v_i && (!m_v || yumi_i);
    y   = yumi_i;
    a   = int'(addr_i);
    @(posedge clk);
    #1;
    if (rst) begin
      m_v = 1'b0;
      m_count = '0;
      for (int k = 0; k < NI; k++) begin
        m_data[k] = '0;
        m_err[k]  = 1'b0;
      end
    end else if (acc) begin
      m_v = 1'b1;
      for (int k = 0; k < NI; k++) {m_err[k], m_data[k]} = ref_lookup(k, a, m_count);
      m_count = m_count + 32'd1;
    end else if (y) begin
      m_v = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b1, 8, 1'b0);
    tick();
    tick();
    for (int k = 0; k < NI; k++) begin
      n_tests++;
      if (v_o[k] !== 1'b0 || data_o[k] !== 32'd0 || err_o[k] !== 1'b0 || ready_o[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset inst%0d: v=%b data=%h err=%b ready=%b, need 0/0/0/1",
                 k, v_o[k], data_o[k], err_o[k], ready_o[k]);
      end
    end
    reset_n = 1'b1;
    drive(1'b0, 0, 1'b0);
  endtask

  task automatic test_cfg_readback();
    drive(1'b1, 0, 1'b0);
    n_tests++;
    if (ready_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ready: got %b need 1", ready_o[0]);
    end
    tick();
    for (int k = 0; k < NI; k++) begin
      n_tests++;
      if (v_o[k] !== 1'b1 || data_o[k] !== CFG_RAW[k] || err_o[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL cfg_idx0 inst%0d: v=%b data=%h err=%b need 1/%h/0", k, v_o[k], data_o[k], err_o[k], CFG_RAW[k]);
      end
    end
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, i, 1'b1);
      n_tests++;
      if (ready_o[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready idx%0d: got %b need 1", i, ready_o[1]);
      end
      tick();
      for (int k = 0; k < NI; k++) begin
        n_tests++;
        if (v_o[k] !== 1'b1 || data_o[k] !== CFG_LV[k][i-1] || err_o[k] !== 1'b0) begin
          n_fail++;
          $display("FAIL level idx%0d inst%0d: v=%b data=%h err=%b need 1/%h/0",
                   i, k, v_o[k], data_o[k], err_o[k], CFG_LV[k][i-1]);
        end
      end
    end
    drive(1'b0, 0, 1'b1);
    tick();
    n_tests++;
    if (v_o[0] !== 1'b0 || data_o[0] !== CFG_LV[0][2]) begin
      n_fail++;
      $display("FAIL drain: v=%b data=%h need 0/%h", v_o[0], data_o[0], CFG_LV[0][2]);
    end
  endtask

  task automatic test_geometry_unmapped();
    logic [31:0] exp_d [5];
    int          idx   [5];
    exp_d = '{32'd32, 32'd64, 32'd8, 32'd8, 32'hDEAD_BEEF};
    idx   = '{4, 5, 6, 7, 12};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, idx[i], m_v);
      tick();
      n_tests++;
      if (v_o[0] !== 1'b1 || data_o[0] !== exp_d[i] || err_o[0] !== (idx[i] == 12)) begin
        n_fail++;
        $display("FAIL geom idx%0d: v=%b data=%h err=%b need 1/%h/%b",
                 idx[i], v_o[0], data_o[0], err_o[0], exp_d[i], idx[i] == 12);
      end
    end
    drive(1'b0, 0, 1'b1);
    tick();
  endtask

  task automatic test_backpressure();
    drive(1'b1, 5, 1'b0);
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 6, 1'b0);
      n_tests++;
      if (ready_o[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_ready cyc%0d: got %b need 0", c, ready_o[0]);
      end
      tick();
      n_tests++;
      if (v_o[0] !== 1'b1 || data_o[0] !== 32'd64 || err_o[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cyc%0d: v=%b data=%h err=%b need 1/40/0", c, v_o[0], data_o[0], err_o[0]);
      end
    end
    drive(1'b1, 6, 1'b1);
    n_tests++;
    if (ready_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b need 1", ready_o[0]);
    end
    tick();
    n_tests++;
    if (v_o[0] !== 1'b1 || data_o[0] !== 32'd8) begin
      n_fail++;
      $display("FAIL bp_release: v=%b data=%h need 1/8", v_o[0], data_o[0]);
    end
    drive(1'b0, 0, 1'b1);
    tick();
  endtask

  task automatic test_counter();
    reset_n = 1'b0;
    drive(1'b0, 0, 1'b0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, int'($urandom_range(0, 15)), m_v);
      tick();
    end
    drive(1'b1, 8, m_v);
    tick();
    for (int k = 0; k < NI; k++) begin
      n_tests++;
      if (data_o[k] !== 32'd10 || err_o[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL count10 inst%0d: data=%h err=%b need a/0", k, data_o[k], err_o[k]);
      end
    end
    drive(1'b0, 0, 1'b1);
    tick();
    force u_dut0.r_req_count = 32'hFFFF_FFFF;
    force u_dut1.r_req_count = 32'hFFFF_FFFF;
    force u_dut2.r_req_count = 32'hFFFF_FFFF;
    force u_dut3.r_req_count = 32'hFFFF_FFFF;
    #1;
    release u_dut0.r_req_count;
    release u_dut1.r_req_count;
    release u_dut2.r_req_count;
    release u_dut3.r_req_count;
    m_count = 32'hFFFF_FFFF;
    drive(1'b1, 8, 1'b0);
    tick();
    n_tests++;
    if (data_o[0] !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL count_max: data=%h need ffffffff", data_o[0]);
    end
    drive(1'b1, 8, 1'b1);
    tick();
    n_tests++;
    if (data_o[0] !== 32'd0 || v_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL count_wrap: v=%b data=%h need 1/0", v_o[0], data_o[0]);
    end
    drive(1'b0, 0, 1'b1);
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 7, 1'b0);
    tick();
    reset_n = 1'b0;
    drive(1'b1, 4, 1'b0);
    tick();
    n_tests++;
    if (v_o[0] !== 1'b0 || data_o[0] !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid: v=%b data=%h need 0/0", v_o[0], data_o[0]);
    end
    reset_n = 1'b1;
    drive(1'b1, 8, 1'b0);
    tick();
    n_tests++;
    if (data_o[0] !== 32'd0 || v_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_count: v=%b data=%h need 1/0", v_o[0], data_o[0]);
    end
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, i, 1'b1);
      tick();
      n_tests++;
      if (data_o[2] !== 32'd0 || err_o[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL infinite_mem idx%0d: data=%h err=%b need 0/0", i, data_o[2], err_o[2]);
      end
    end
    drive(1'b0, 0, 1'b1);
    tick();
  endtask

  task automatic test_random();
    logic v, y;
    for (int c = 0; c < 400; c++) begin
      v = 1'($urandom_range(0, 3) != 0);
      y = m_v && ($urandom_range(0, 2) != 0);
      drive(v, int'($urandom_range(0, 15)), y);
      for (int k = 0; k < NI; k++) begin
        n_tests++;
        if (ready_o[k] !== (!m_v || y)) begin
          n_fail++;
          $display("FAIL rand_ready c%0d inst%0d: got %b need %b", c, k, ready_o[k], !m_v || y);
        end
      end
      tick();
      for (int k = 0; k < NI; k++) begin
        n_tests++;
        if (v_o[k] !== m_v || (m_v && (data_o[k] !== m_data[k] || err_o[k] !== m_err[k]))) begin
          n_fail++;
          $display("FAIL rand_resp c%0d inst%0d: v=%b data=%h err=%b need %b/%h/%b",
                   c, k, v_o[k], data_o[k], err_o[k], m_v, m_data[k], m_err[k]);
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    v_i     = 1'b0;
    addr_i  = '0;
    yumi_i  = 1'b0;
    m_v     = 1'b0;
    m_count = '0;
    for (int k = 0; k < NI; k++) begin
      m_data[k] = '0;
      m_err[k]  = 1'b0;
    end
    test_reset();
    test_cfg_readback();
    test_geometry_unmapped();
    test_backpressure();
    test_counter();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
